// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - registered RV32I decode stage with register file, hazard detect and ID/EX handshake (option: RF_WB_BYPASS_EN)
module id_stage_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_alu_src_imm,
    output logic            out_wb_sel_mem,
    output logic [3:0]      out_alu_op,
    output logic            out_illegal
);
    localparam int          AW     = $clog2(NREG);
    localparam logic [5:0]  NREG_L = 6'(NREG);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // control vector bit positions: {reg_write, mem_read, mem_write, branch, jump, alu_src_imm, wb_sel_mem}
    localparam int C_RW = 6, C_MR = 5, C_MW = 4, C_BR = 3, C_JP = 2, C_ASI = 1, C_WBM = 0;

    logic [XLEN-1:0] r_rf [NREG];

    logic            r_valid;
    logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic [6:0]      r_ctl;
    logic [3:0]      r_alu_op;
    logic            r_illegal;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic [6:0]      w_ctl_raw, w_ctl;
    logic [3:0]      w_alu_raw, w_alu;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic            w_use1, w_use2, w_legal_op, w_bad_idx, w_illegal;
    logic            w_wb_ok, w_byp1, w_byp2;
    logic [XLEN-1:0] w_rs1_data, w_rs2_data;
    logic            w_advance, w_hazard;

    assign w_opcode = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_rs1    = in_instr[19:15];
    assign w_rs2    = in_instr[24:20];
    assign w_rd     = in_instr[11:7];

    // Opcode decode: controls, immediate format, ALU op and which source indices are read
    always_comb begin
        w_ctl_raw  = '0;
        w_alu_raw  = '0;
        w_imm32    = '0;
        w_use1     = 1'b0;
        w_use2     = 1'b0;
        w_legal_op = 1'b1;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_ctl_raw[C_RW] = 1'b1; w_ctl_raw[C_ASI] = 1'b1;
                w_imm32 = {in_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                w_ctl_raw[C_JP] = 1'b1; w_ctl_raw[C_RW] = 1'b1;
                w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                w_ctl_raw[C_JP] = 1'b1; w_ctl_raw[C_RW] = 1'b1; w_ctl_raw[C_ASI] = 1'b1;
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                w_use1  = 1'b1;
            end
            OPC_BRANCH: begin
                w_ctl_raw[C_BR] = 1'b1;
                w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
                w_use1  = 1'b1; w_use2 = 1'b1;
            end
            OPC_LOAD: begin
                w_ctl_raw[C_MR] = 1'b1; w_ctl_raw[C_RW] = 1'b1;
                w_ctl_raw[C_ASI] = 1'b1; w_ctl_raw[C_WBM] = 1'b1;
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                w_use1  = 1'b1;
            end
            OPC_STORE: begin
                w_ctl_raw[C_MW] = 1'b1; w_ctl_raw[C_ASI] = 1'b1;
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                w_use1  = 1'b1; w_use2 = 1'b1;
            end
            OPC_OPIMM: begin
                w_ctl_raw[C_RW] = 1'b1; w_ctl_raw[C_ASI] = 1'b1;
                w_imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                w_alu_raw = {(w_f3 == 3'b101) & in_instr[30], w_f3};
                w_use1    = 1'b1;
            end
            OPC_OP: begin
                w_ctl_raw[C_RW] = 1'b1;
                w_alu_raw = {in_instr[30], w_f3};
                w_use1    = 1'b1; w_use2 = 1'b1;
            end
            default: w_legal_op = 1'b0;
        endcase
    end

    // RV32E rejects any index the instruction actually uses beyond the implemented file
    assign w_bad_idx = (w_use1 && ({1'b0, w_rs1} >= NREG_L)) ||
                       (w_use2 && ({1'b0, w_rs2} >= NREG_L)) ||
                       (w_ctl_raw[C_RW] && ({1'b0, w_rd} >= NREG_L));
    assign w_illegal = !w_legal_op || w_bad_idx;
    assign w_ctl     = w_illegal ? 7'b0 : w_ctl_raw;
    assign w_alu     = w_illegal ? 4'b0 : w_alu_raw;
    assign w_imm     = XLEN'($signed(w_imm32));

    assign w_wb_ok = wb_we && (wb_rd != 5'd0) && ({1'b0, wb_rd} < NREG_L);
`ifdef RF_WB_BYPASS_EN
    assign w_byp1 = w_wb_ok && (wb_rd == w_rs1);
    assign w_byp2 = w_wb_ok && (wb_rd == w_rs2);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    // Asynchronous register reads; x0 and unimplemented indices read as zero
    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        if (w_byp1)
            w_rs1_data = wb_data;
        else if (w_rs1 != 5'd0 && {1'b0, w_rs1} < NREG_L)
            w_rs1_data = r_rf[w_rs1[AW-1:0]];
        if (w_byp2)
            w_rs2_data = wb_data;
        else if (w_rs2 != 5'd0 && {1'b0, w_rs2} < NREG_L)
            w_rs2_data = r_rf[w_rs2[AW-1:0]];
    end

    assign w_advance = !r_valid || out_ready;
    assign w_hazard  = r_valid && r_ctl[C_MR] && (r_rd != 5'd0) &&
                       ((w_use1 && (w_rs1 == r_rd)) || (w_use2 && (w_rs2 == r_rd)));
    assign in_ready  = w_advance && !w_hazard && !flush;

    // Register file write port; runs independently of flush and stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (w_wb_ok) begin
            r_rf[wb_rd[AW-1:0]] <= wb_data;
        end
    end

    // ID/EX payload register: flush, then load-use bubble, then load, else hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0; r_pc <= '0; r_rs1_data <= '0; r_rs2_data <= '0; r_imm <= '0;
            r_rs1 <= '0; r_rs2 <= '0; r_rd <= '0; r_ctl <= '0; r_alu_op <= '0; r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_advance) begin
            if (w_hazard || !in_valid) begin
                r_valid <= 1'b0;
            end else begin
                r_valid    <= 1'b1;
                r_pc       <= in_pc;
                r_rs1_data <= w_rs1_data;
                r_rs2_data <= w_rs2_data;
                r_imm      <= w_legal_op ? w_imm : '0;
                r_rs1      <= w_rs1;
                r_rs2      <= w_rs2;
                r_rd       <= w_rd;
                r_ctl      <= w_ctl;
                r_alu_op   <= w_alu;
                r_illegal  <= w_illegal;
            end
        end
    end

    assign out_valid       = r_valid;
    assign out_pc          = r_pc;
    assign out_rs1_data    = r_rs1_data;
    assign out_rs2_data    = r_rs2_data;
    assign out_imm         = r_imm;
    assign out_rs1         = r_rs1;
    assign out_rs2         = r_rs2;
    assign out_rd          = r_rd;
    assign out_reg_write   = r_ctl[C_RW];
    assign out_mem_read    = r_ctl[C_MR];
    assign out_mem_write   = r_ctl[C_MW];
    assign out_branch      = r_ctl[C_BR];
    assign out_jump        = r_ctl[C_JP];
    assign out_alu_src_imm = r_ctl[C_ASI];
    assign out_wb_sel_mem  = r_ctl[C_WBM];
    assign out_alu_op      = r_alu_op;
    assign out_illegal     = r_illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - self-checking bench for id_stage_pipe
module tb_id_stage_pipe;
    typedef logic [154:0] pay_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, wb_we, out_ready;
    logic [31:0] in_instr, in_pc, wb_data;
    logic [4:0]  wb_rd;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_alu_src_imm, out_wb_sel_mem;
    logic [3:0]  out_alu_op;
    logic        out_illegal;

    logic        s_in_valid;
    logic [31:0] s_in_instr, s_in_pc;
    logic        u_in_ready, u_out_valid;
    logic [31:0] u_out_pc, u_out_rs1_data, u_out_rs2_data, u_out_imm;
    logic [4:0]  u_out_rs1, u_out_rs2, u_out_rd;
    logic        u_rw, u_mr, u_mw, u_br, u_jp, u_asi, u_wbm;
    logic [3:0]  u_out_alu_op;
    logic        u_out_illegal;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_rf [32];
    pay_t        q_pay [$];
    logic [31:0] q_ins [$];
    logic [6:0]  ops [11] = '{7'h03, 7'h03, 7'h33, 7'h13, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h7F};

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_branch(out_branch), .out_jump(out_jump),
        .out_alu_src_imm(out_alu_src_imm), .out_wb_sel_mem(out_wb_sel_mem), .out_alu_op(out_alu_op),
        .out_illegal(out_illegal));

    id_stage_pipe #(.XLEN(32), .NREG(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(u_in_ready), .in_instr(s_in_instr), .in_pc(s_in_pc),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(u_out_valid), .out_ready(out_ready),
        .out_pc(u_out_pc), .out_rs1_data(u_out_rs1_data), .out_rs2_data(u_out_rs2_data), .out_imm(u_out_imm),
        .out_rs1(u_out_rs1), .out_rs2(u_out_rs2), .out_rd(u_out_rd), .out_reg_write(u_rw),
        .out_mem_read(u_mr), .out_mem_write(u_mw), .out_branch(u_br), .out_jump(u_jp),
        .out_alu_src_imm(u_asi), .out_wb_sel_mem(u_wbm), .out_alu_op(u_out_alu_op),
        .out_illegal(u_out_illegal));

    wire pay_t dut_pay = {out_pc, out_rs1_data, out_rs2_data, out_imm, out_rs1, out_rs2, out_rd,
                          out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_alu_src_imm,
                          out_wb_sel_mem, out_alu_op, out_illegal};
    wire [6:0] dut_ctl = {out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_alu_src_imm, out_wb_sel_mem};
    wire [6:0] u_ctl   = {u_rw, u_mr, u_mw, u_br, u_jp, u_asi, u_wbm};

    // Reference decode from the RV32I tables; control order {rw, mr, mw, br, jp, asi, wbm}
    function automatic pay_t exp_payload(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2);
        logic [31:0] imm = 32'd0;
        logic [6:0]  ctl = 7'b0;
        logic [3:0]  alu = 4'b0;
        logic        ill = 1'b0;
        logic [31:0] sh20 = 32'($signed(ins) >>> 20);
        case (ins[6:0])
            7'h37, 7'h17: begin ctl = 7'b1000010; imm = ins & 32'hFFFFF000; end
            7'h6F: begin ctl = 7'b1000100;
                imm = (32'($signed(ins) >>> 11) & 32'hFFF00000) | ({24'd0, ins[19:12]} << 12) | ({31'd0, ins[20]} << 11) | ({22'd0, ins[30:21]} << 1); end
            7'h67: begin ctl = 7'b1000110; imm = sh20; end
            7'h63: begin ctl = 7'b0001000;
                imm = (32'($signed(ins) >>> 19) & 32'hFFFFF000) | ({31'd0, ins[7]} << 11) | ({26'd0, ins[30:25]} << 5) | ({28'd0, ins[11:8]} << 1); end
            7'h03: begin ctl = 7'b1100011; imm = sh20; end
            7'h23: begin ctl = 7'b0010010; imm = (sh20 & ~32'h1F) | {27'd0, ins[11:7]}; end
            7'h13: begin ctl = 7'b1000010; imm = sh20; alu = {(ins[14:12] == 3'b101) && ins[30], ins[14:12]}; end
            7'h33: begin ctl = 7'b1000000; alu = {ins[30], ins[14:12]}; end
            default: ill = 1'b1;
        endcase
        return {pc, d1, d2, imm, ins[19:15], ins[24:20], ins[11:7], ctl, alu, ill};
    endfunction

    function automatic bit uses_rs1(input logic [6:0] op);
        return op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    endfunction
    function automatic bit uses_rs2(input logic [6:0] op);
        return op inside {7'h63, 7'h23, 7'h33};
    endfunction

    function automatic bit load_use(input logic [31:0] held, input logic [31:0] ins);
        if (held[6:0] != 7'h03 || held[11:7] == 5'd0) return 1'b0;
        return (uses_rs1(ins[6:0]) && ins[19:15] == held[11:7]) || (uses_rs2(ins[6:0]) && ins[24:20] == held[11:7]);
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] idx);
        logic [31:0] v = (idx == 5'd0) ? 32'd0 : model_rf[idx];
`ifdef RF_WB_BYPASS_EN
        if (wb_we && wb_rd != 5'd0 && wb_rd == idx) v = wb_data;
`endif
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        out_ready = 1'b1; in_instr = 32'h13; in_pc = 32'd0; s_in_valid = 1'b0; s_in_instr = 32'h13; s_in_pc = 32'd0;
        cyc(); cyc(); reset = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        n_checks++; if (dut_pay !== '0) begin n_fail++; $display("FAIL reset_payload got %h exp 0", dut_pay); end
        cyc();
    endtask

    task automatic test_addi();
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234; cyc();
        wb_we = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF28313; in_pc = 32'h100;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_in_ready got %0b exp 1", in_ready); end
        cyc(); in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %0b exp 1", out_valid); end
        n_checks++; if (out_rs1_data !== 32'h1234) begin n_fail++; $display("FAIL addi_rs1_data got %h exp 1234", out_rs1_data); end
        n_checks++; if (out_imm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_imm got %h exp ffffffff", out_imm); end
        n_checks++; if (dut_pay !== exp_payload(32'hFFF28313, 32'h100, 32'h1234, 32'h0))
            begin n_fail++; $display("FAIL addi_payload got %h exp %h", dut_pay, exp_payload(32'hFFF28313, 32'h100, 32'h1234, 32'h0)); end
    endtask

    task automatic test_load_use();
        in_valid = 1'b1; in_instr = 32'h0000A383; in_pc = 32'h200; out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_lw_ready got %0b exp 1", in_ready); end
        cyc(); in_instr = 32'h00238433; in_pc = 32'h204;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_hazard_ready got %0b exp 0", in_ready); end
        n_checks++; if ({out_valid, out_mem_read} !== 2'b11) begin n_fail++; $display("FAIL lu_lw_held got %b exp 11", {out_valid, out_mem_read}); end
        cyc();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got %0b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_after_bubble_ready got %0b exp 1", in_ready); end
        cyc(); in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({out_valid, out_pc, out_rd, out_alu_op} !== {1'b1, 32'h204, 5'd8, 4'b0000})
            begin n_fail++; $display("FAIL lu_add_issue got %h exp %h", {out_valid, out_pc, out_rd, out_alu_op}, {1'b1, 32'h204, 5'd8, 4'b0000}); end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h300; out_ready = 1'b1;
        cyc(); out_ready = 1'b0; in_instr = 32'h00100093; in_pc = 32'h304;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready cyc %0d got %0b exp 0", i, in_ready); end
            n_checks++; if ({out_valid, dut_pay} !== {1'b1, exp_payload(32'h402081B3, 32'h300, 32'h0, 32'h0)})
                begin n_fail++; $display("FAIL stall_payload cyc %0d got %h exp %h", i, dut_pay, exp_payload(32'h402081B3, 32'h300, 32'h0, 32'h0)); end
            cyc();
        end
        n_checks++; if (out_alu_op !== 4'b1000) begin n_fail++; $display("FAIL stall_sub_alu got %b exp 1000", out_alu_op); end
        out_ready = 1'b1; in_valid = 1'b0; cyc();
    endtask

    task automatic test_bypass();
        logic [31:0] exp_d;
`ifdef RF_WB_BYPASS_EN
        exp_d = 32'hABCD;
`else
        exp_d = 32'h1111;
`endif
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h1111; cyc();
        wb_data = 32'hABCD; in_valid = 1'b1; in_instr = 32'h000204B3; in_pc = 32'h400;
        cyc(); wb_we = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_rs1_data !== exp_d) begin n_fail++; $display("FAIL bypass_rs1 got %h exp %h", out_rs1_data, exp_d); end
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD; cyc();
        wb_we = 1'b0; in_valid = 1'b1; in_instr = 32'h000004B3; in_pc = 32'h408;
        cyc(); in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({out_rs1_data, out_rs2_data} !== 64'd0) begin n_fail++; $display("FAIL x0_read got %h exp 0", {out_rs1_data, out_rs2_data}); end
        cyc();
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_instr = 32'hFFF28313; in_pc = 32'h500; out_ready = 1'b1;
        cyc(); out_ready = 1'b0; flush = 1'b1; in_instr = 32'h000204B3; in_pc = 32'h504;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %0b exp 0", in_ready); end
        cyc(); flush = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b exp 0", out_valid); end
        cyc(); in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({out_valid, out_pc} !== {1'b1, 32'h504}) begin n_fail++; $display("FAIL flush_reoffer got %h exp %h", {out_valid, out_pc}, {1'b1, 32'h504}); end
        out_ready = 1'b1; cyc();
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_instr = 32'h0000007F; in_pc = 32'h600;
        s_in_valid = 1'b1; s_in_instr = 32'h002088B3; s_in_pc = 32'h600;
        cyc(); in_valid = 1'b0; s_in_instr = 32'h002083B3;
        @(negedge clk);
        n_checks++; if ({out_illegal, dut_ctl, out_alu_op} !== 12'h800) begin n_fail++; $display("FAIL illegal_opcode got %h exp 800", {out_illegal, dut_ctl, out_alu_op}); end
        n_checks++; if ({u_out_illegal, u_ctl, u_out_alu_op} !== 12'h800) begin n_fail++; $display("FAIL illegal_rv32e got %h exp 800", {u_out_illegal, u_ctl, u_out_alu_op}); end
        cyc(); s_in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({u_out_illegal, u_ctl} !== 8'h40) begin n_fail++; $display("FAIL legal_rv32e got %h exp 40", {u_out_illegal, u_ctl}); end
        cyc();
    endtask

    task automatic test_random();
        bit held, exp_adv, exp_ir;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_we = 1'b0; cyc(); reset = 1'b0;
        for (int r = 0; r < 32; r++) model_rf[r] = 32'd0;
        q_pay.delete(); q_ins.delete();
        for (int n = 0; n < 600; n++) begin
            in_instr        = $urandom;
            in_instr[6:0]   = ops[$urandom_range(10, 0)];
            in_instr[11:7]  = 5'($urandom_range(7, 0));
            in_instr[19:15] = 5'($urandom_range(7, 0));
            in_instr[24:20] = 5'($urandom_range(7, 0));
            in_pc     = $urandom;
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(3, 0) != 0);
            flush     = ($urandom_range(19, 0) == 0);
            wb_we     = $urandom_range(1, 0) == 1;
            wb_rd     = 5'($urandom_range(7, 0));
            wb_data   = $urandom;
            @(negedge clk);
            held    = (q_ins.size() != 0);
            exp_adv = !held || out_ready;
            exp_ir  = exp_adv && !(held && load_use(q_ins[0], in_instr)) && !flush;
            n_checks++; if (in_ready !== exp_ir) begin n_fail++; $display("FAIL rnd_in_ready n=%0d got %0b exp %0b", n, in_ready, exp_ir); end
            n_checks++; if (out_valid !== held) begin n_fail++; $display("FAIL rnd_out_valid n=%0d got %0b exp %0b", n, out_valid, held); end
            if (flush) begin
                q_pay.delete(); q_ins.delete();
            end else begin
                if (held && out_ready) begin
                    n_checks++; if (dut_pay !== q_pay[0]) begin n_fail++; $display("FAIL rnd_payload n=%0d got %h exp %h", n, dut_pay, q_pay[0]); end
                    void'(q_pay.pop_front()); void'(q_ins.pop_front());
                end
                if (exp_ir && in_valid) begin
                    q_pay.push_back(exp_payload(in_instr, in_pc, rd_model(in_instr[19:15]), rd_model(in_instr[24:20])));
                    q_ins.push_back(in_instr);
                end
            end
            if (wb_we && wb_rd != 5'd0) model_rf[wb_rd] = wb_data;
            cyc();
        end
        in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_stall();
        test_bypass();
        test_flush();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised, registered successor to the combinational decode stage. It decodes one RV32I instruction per cycle and contains the integer register file, the immediate generator and the control decoder. It detects load-use hazards against the instruction it currently holds and presents a registered ID/EX payload to the execute stage over a valid/ready handshake. It sits between the fetch buffer and the EX stage and accepts the WB write port.

## Interface
Parameters:
- XLEN, 32, datapath width of the register file, PC and immediates. Immediates are sign-extended to XLEN.
- NREG, 32, number of architectural registers. Legal values are 32 (RV32I) and 16 (RV32E).

Ports (reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage accepts the offered instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of in_instr
- flush  in  1  kill the held payload; refuse input this cycle
- wb_we / wb_rd / wb_data  in  1 / 5 / XLEN  register-file write port
- out_valid  out  1  ID/EX payload valid
- out_ready  in  1  EX consumes the payload
- out_pc, out_rs1_data, out_rs2_data, out_imm  out  XLEN  registered payload
- out_rs1, out_rs2, out_rd  out  5  register indices
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_alu_src_imm, out_wb_sel_mem  out  1  registered controls
- out_alu_op  out  4  ALU operation
- out_illegal  out  1  instruction was undecodable

## Operation
- **Fields:** rs1=[19:15], rs2=[24:20], rd=[11:7].
- **Register file:**
  - NREG×XLEN, two asynchronous read ports.
  - Writes occur on the clock edge when wb_we=1 and wb_rd≠0.
  - x0 always reads as 0.
- **Immediates:** I, S, B, U and J formats, with RV32I bit placement, sign-extended to XLEN. R-type immediate is 0.
- **Decoded opcodes:**
  - LUI: reg_write, alu_src_imm.
  - AUIPC: reg_write, alu_src_imm.
  - JAL: jump, reg_write.
  - JALR: jump, reg_write, alu_src_imm.
  - BRANCH: branch.
  - LOAD: mem_read, reg_write, alu_src_imm, wb_sel_mem.
  - STORE: mem_write, alu_src_imm.
  - OP-IMM: reg_write, alu_src_imm.
  - OP: reg_write.
- **alu_op:**
  - For OP: {instr[30], funct3}.
  - For OP-IMM: {instr[30] when funct3=101, else 0; funct3}.
  - For all other opcodes: 4'b0000.
- **Illegal instructions:** any other opcode, or (NREG=16 and any used index ≥16). The result is out_illegal=1 with all other controls 0.
- **Register usage for hazards:**
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - rs2 is used by BRANCH, STORE and OP.
- **advance** = !out_valid | out_ready.
- **hazard** = out_valid & out_mem_read & out_rd≠0 & ((rs1 used & rs1==out_rd) | (rs2 used & rs2==out_rd)).
- **in_ready** = advance & !hazard & !flush.
- **Each clock edge, in priority order:**
  1. reset: all out_* registers and out_valid go to 0; all registers are cleared to 0.
  2. flush: out_valid goes to 0.
  3. advance & hazard: out_valid goes to 0 (bubble). The instruction stays at the input.
  4. advance & in_valid & in_ready: the payload is loaded and out_valid goes to 1.
  5. advance & !in_valid: out_valid goes to 0.
  6. Otherwise: the payload holds, stable.
- The WB write proceeds even during reset-free flush and stall cycles.

## Timing
- Latency is 1 cycle from acceptance (in_valid & in_ready) to out_valid.
- Throughput is 1 instruction per cycle when out_ready=1 and there is no hazard.
- A load-use dependency inserts exactly one bubble. The consumer is accepted on the following cycle.
- While out_valid=1 and out_ready=0, all out_* signals are stable.
- in_ready is combinational from out_valid, out_ready, flush, the held payload and in_instr.
- Register-file data captured in the payload is the value read on the acceptance cycle.
- Reset mid-operation drops any held payload. No partial state survives.

## Configuration
- **RF_WB_BYPASS_EN defined:** a same-cycle write (wb_we, wb_rd≠0, wb_rd==rs) forwards wb_data onto that read port, so the captured payload sees the new value.
- **RF_WB_BYPASS_EN undefined:** the read returns the pre-write value. WB must then write at least one cycle before a dependent decode.

## Test plan
- Reset, then write x5=0x1234 via WB; a cycle later decode ADDI x6,x5,-1 (0xFFF28313) -> out_rs1_data=0x1234, out_imm=0xFFFFFFFF, out_alu_op=0000, reg_write=1, alu_src_imm=1.
- Decode LW x7,0(x1) then ADD x8,x7,x2 back-to-back with out_ready=1 -> in_ready=0 for one cycle and one out_valid=0 bubble, then ADD issues with out_alu_op=0000.
- Decode SUB x3,x1,x2 (0x402081B3) with out_ready=0 for 3 cycles -> payload stable and in_ready=0; out_alu_op=1000.
- Write x4=0xABCD via WB in the same cycle as decoding ADD x9,x4,x0 -> rs1_data=0xABCD with RF_WB_BYPASS_EN, and the old value without it. Also a WB write to x0 -> x0 still reads 0.
- Assert flush while in_valid=1 and out_valid=1 -> next cycle out_valid=0, and the offered instruction is not consumed.
- Present opcode 0x7F, and with NREG=16 ADD x17,x1,x2 -> out_illegal=1 with all other controls 0.
